// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - MIPS-subset instruction encoder with pseudo-op expansion
//
// Turns one command (class, register fields, immediate) into one or two
// 32-bit machine words on a valid/ready output stream.
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake; cmd_ready is high only in IDLE
//   cmd_kind              0 R, 1 I, 2 J, 3 NOP, 4 LI, 5 MOVE, 6 BLT, 7 BGE
//   cmd_op/cmd_func       opcode / funct, emitted verbatim
//   cmd_rs/rt/rd/shamt    register and shift fields
//   cmd_imm               [15:0] I/branch, [25:0] J, all 32 bits for LI
//   instr_valid/ready     output word handshake
//   instr, instr_last     encoded word and end-of-command marker
//   instr_cnt             words accepted by the consumer, wraps
module instr_encoder #(
    parameter int AT_REG = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_kind,
    input  logic [5:0]       cmd_op,
    input  logic [5:0]       cmd_func,
    input  logic [4:0]       cmd_rs,
    input  logic [4:0]       cmd_rt,
    input  logic [4:0]       cmd_rd,
    input  logic [4:0]       cmd_shamt,
    input  logic [31:0]      cmd_imm,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [31:0]      instr,
    output logic             instr_last,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OUT1 = 2'd1,
        OUT2 = 2'd2
    } state_t;

    localparam logic [2:0] K_R    = 3'd0;
    localparam logic [2:0] K_I    = 3'd1;
    localparam logic [2:0] K_J    = 3'd2;
    localparam logic [2:0] K_NOP  = 3'd3;
    localparam logic [2:0] K_LI   = 3'd4;
    localparam logic [2:0] K_MOVE = 3'd5;
    localparam logic [2:0] K_BLT  = 3'd6;
    localparam logic [2:0] K_BGE  = 3'd7;

    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LUI  = 6'h0F;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    localparam logic [4:0] AT   = AT_REG[4:0];
    localparam logic [4:0] ZERO = 5'd0;

    state_t            state_q, state_d;
    logic [31:0]       instr_q, instr_d;
    logic [31:0]       word2_q, word2_d;
    logic              last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [31:0]       enc_w1, enc_w2;
    logic              enc_two;

    // Word(s) for the command currently on the input; only consumed at accept.
    always_comb begin
        enc_w1  = 32'h0;
        enc_w2  = 32'h0;
        enc_two = 1'b0;
        case (cmd_kind)
            K_R:    enc_w1 = {6'b0, cmd_rs, cmd_rt, cmd_rd, cmd_shamt, cmd_func};
            K_I:    enc_w1 = {cmd_op, cmd_rs, cmd_rt, cmd_imm[15:0]};
            K_J:    enc_w1 = {cmd_op, cmd_imm[25:0]};
            K_NOP:  enc_w1 = 32'h0;
            K_MOVE: enc_w1 = {6'b0, cmd_rs, ZERO, cmd_rd, 5'd0, FN_ADDU};
            K_LI: begin
                if (cmd_imm[31:16] == 16'h0) begin
                    enc_w1 = {OP_ORI, ZERO, cmd_rt, cmd_imm[15:0]};
                end else if (cmd_imm[15:0] == 16'h0) begin
                    enc_w1 = {OP_LUI, ZERO, cmd_rt, cmd_imm[31:16]};
                end else begin
                    enc_w1  = {OP_LUI, ZERO, cmd_rt, cmd_imm[31:16]};
                    enc_w2  = {OP_ORI, cmd_rt, cmd_rt, cmd_imm[15:0]};
                    enc_two = 1'b1;
                end
            end
            K_BLT, K_BGE: begin
                enc_w1  = {6'b0, cmd_rs, cmd_rt, AT, 5'd0, FN_SLT};
                enc_w2  = {(cmd_kind == K_BLT) ? OP_BNE : OP_BEQ, AT, ZERO, cmd_imm[15:0]};
                enc_two = 1'b1;
            end
            default: enc_w1 = 32'h0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        word2_d = word2_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d = OUT1;
                    instr_d = enc_w1;
                    word2_d = enc_w2;
                    last_d  = ~enc_two;
                end
            end
            OUT1: begin
                if (instr_ready) begin
                    cnt_d = cnt_q + 1'b1;
                    // In OUT1 last_q low means a second word is still owed.
                    if (!last_q) begin
                        state_d = OUT2;
                        instr_d = word2_q;
                        last_d  = 1'b1;
                    end else begin
                        state_d = IDLE;
                        instr_d = 32'h0;
                        last_d  = 1'b0;
                    end
                end
            end
            OUT2: begin
                if (instr_ready) begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = IDLE;
                    instr_d = 32'h0;
                    last_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                instr_d = 32'h0;
                last_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            instr_q <= 32'h0;
            word2_q <= 32'h0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            word2_q <= word2_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cmd_ready   = (state_q == IDLE);
    assign instr_valid = (state_q != IDLE);
    assign instr       = instr_q;
    assign instr_last  = last_q;
    assign instr_cnt   = cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - randomized self-checking bench for instr_encoder
module tb_instr_encoder;

    localparam int AT_REG = 1;
    localparam int CNT_W  = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [2:0]       cmd_kind = '0;
    logic [5:0]       cmd_op = '0;
    logic [5:0]       cmd_func = '0;
    logic [4:0]       cmd_rs = '0;
    logic [4:0]       cmd_rt = '0;
    logic [4:0]       cmd_rd = '0;
    logic [4:0]       cmd_shamt = '0;
    logic [31:0]      cmd_imm = '0;
    logic             instr_valid;
    logic             instr_ready = 1'b0;
    logic [31:0]      instr;
    logic             instr_last;
    logic [CNT_W-1:0] instr_cnt;

    instr_encoder #(.AT_REG(AT_REG), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_kind(cmd_kind), .cmd_op(cmd_op), .cmd_func(cmd_func),
        .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd),
        .cmd_shamt(cmd_shamt), .cmd_imm(cmd_imm),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_last(instr_last), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Expected output words, {last, word}, oldest first.
    logic [32:0] exp_q[$];
    int          model_cnt = 0;

    bit rnd_ready = 1'b0;
    bit hold_ready = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoding built from the instruction-format definitions.
    function automatic logic [31:0] r_fmt(input int rs, rt, rd, sh, fn);
        return (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | (32'(sh) << 6) | 32'(fn);
    endfunction

    function automatic logic [31:0] i_fmt(input int op, rs, rt, input logic [31:0] imm);
        return (32'(op) << 26) | (32'(rs) << 21) | (32'(rt) << 16) | (imm & 32'hFFFF);
    endfunction

    function automatic void model(input int kind, op, fn, rs, rt, rd, sh, input logic [31:0] imm,
                                  output logic [31:0] w1, output logic [31:0] w2, output int n);
        logic [31:0] hi, lo;
        hi = imm >> 16;
        lo = imm & 32'hFFFF;
        w2 = 32'h0;
        n  = 1;
        case (kind)
            0: w1 = r_fmt(rs, rt, rd, sh, fn);
            1: w1 = i_fmt(op, rs, rt, imm);
            2: w1 = (32'(op) << 26) | (imm & 32'h03FF_FFFF);
            3: w1 = 32'h0;
            4: begin
                if (hi == 0)      w1 = i_fmt(13, 0, rt, lo);
                else if (lo == 0) w1 = i_fmt(15, 0, rt, hi);
                else begin
                    w1 = i_fmt(15, 0, rt, hi);
                    w2 = i_fmt(13, rt, rt, lo);
                    n  = 2;
                end
            end
            5: w1 = r_fmt(rs, 0, rd, 0, 33);
            default: begin
                w1 = r_fmt(rs, rt, AT_REG, 0, 42);
                w2 = i_fmt((kind == 6) ? 5 : 4, AT_REG, 0, imm);
                n  = 2;
            end
        endcase
    endfunction

    // Per-cycle comparison of every output against the queue model.
    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
            model_cnt = 0;
        end else begin
            chk("instr_cnt", 32'(instr_cnt), 32'(model_cnt[CNT_W-1:0]));
            chk("cmd_ready", 32'(cmd_ready), 32'(exp_q.size() == 0));
            chk("instr_valid", 32'(instr_valid), 32'(exp_q.size() != 0));
            if (instr_valid && exp_q.size() != 0) begin
                chk("instr", instr, exp_q[0][31:0]);
                chk("instr_last", 32'(instr_last), 32'(exp_q[0][32]));
                if (instr_ready) begin
                    void'(exp_q.pop_front());
                    model_cnt++;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (hold_ready)     instr_ready = 1'b0;
            else if (rnd_ready) instr_ready = 1'($urandom_range(0, 1));
            else                instr_ready = 1'b1;
        end
    end

    task automatic send(input int kind, op, fn, rs, rt, rd, sh, input logic [31:0] imm);
        logic [31:0] w1, w2;
        int n;
        bit acc;
        model(kind, op, fn, rs, rt, rd, sh, imm, w1, w2, n);
        @(posedge clk);
        #1;
        cmd_kind  = 3'(kind);
        cmd_op    = 6'(op);
        cmd_func  = 6'(fn);
        cmd_rs    = 5'(rs);
        cmd_rt    = 5'(rt);
        cmd_rd    = 5'(rd);
        cmd_shamt = 5'(sh);
        cmd_imm   = imm;
        cmd_valid = 1'b1;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            acc = cmd_ready;
            @(posedge clk);
            if (acc) begin
                exp_q.push_back({(n == 1), w1});
                if (n == 2) exp_q.push_back({1'b1, w2});
                break;
            end
            if (t == 299) chk("accept_timeout", 32'd0, 32'd1);
        end
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
            if (t == 299) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        end
        @(negedge clk);
    endtask

    task automatic pin(input string name, input int kind, rs, rt, rd, fn, input logic [31:0] imm,
                       input logic [31:0] e1, input logic [31:0] e2);
        logic [31:0] w1, w2;
        int n;
        model(kind, 0, fn, rs, rt, rd, 0, imm, w1, w2, n);
        chk({name, "_w1"}, w1, e1);
        if (n == 2) chk({name, "_w2"}, w2, e2);
    endtask

    initial begin
        logic [15:0] cnt_before;
        logic [31:0] imm;
        int kind;

        pin("pin_li2", 4, 0, 8, 0, 0, 32'h1234_5678, 32'h3C08_1234, 32'h3508_5678);
        pin("pin_li_lo", 4, 0, 9, 0, 0, 32'h0000_ABCD, 32'h3409_ABCD, 32'h0);
        pin("pin_li_hi", 4, 0, 9, 0, 0, 32'h0001_0000, 32'h3C09_0001, 32'h0);
        pin("pin_r", 0, 1, 2, 3, 33, 32'h0, 32'h0022_1821, 32'h0);
        pin("pin_move", 5, 7, 0, 2, 0, 32'h0, 32'h00E0_1021, 32'h0);
        pin("pin_blt", 6, 4, 5, 0, 0, 32'h3, 32'h0085_082A, 32'h1420_0003);
        pin("pin_bge", 7, 4, 5, 0, 0, 32'h3, 32'h0085_082A, 32'h1020_0003);

        #1;
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_last", 32'(instr_last), 32'd0);
        chk("rst_cnt", 32'(instr_cnt), 32'd0);
        #22 reset = 1'b1;

        send(4, 0, 0, 0, 8, 0, 0, 32'h1234_5678);
        drain();
        chk("li_cnt", 32'(instr_cnt), 32'd2);
        send(4, 0, 0, 0, 9, 0, 0, 32'h0000_ABCD);
        send(4, 0, 0, 0, 9, 0, 0, 32'h0001_0000);
        send(0, 0, 33, 1, 2, 3, 0, 32'h0);
        send(5, 0, 0, 7, 0, 2, 0, 32'h0);
        send(6, 0, 0, 4, 5, 0, 0, 32'h3);
        send(7, 0, 0, 4, 5, 0, 0, 32'h3);
        send(4, 0, 0, 0, 0, 0, 0, 32'h0);
        drain();

        // Backpressure during OUT1 of a two-word LI.
        hold_ready  = 1'b1;
        instr_ready = 1'b0;
        cnt_before  = instr_cnt;
        send(4, 0, 0, 0, 8, 0, 0, 32'h1234_5678);
        repeat (3) begin
            @(negedge clk);
            chk("bp_instr", instr, 32'h3C08_1234);
            chk("bp_last", 32'(instr_last), 32'd0);
            chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("bp_cnt", 32'(instr_cnt), 32'(cnt_before));
        end
        hold_ready = 1'b0;
        drain();

        // Randomized commands under random consumer backpressure.
        rnd_ready = 1'b1;
        for (int i = 0; i < 80; i++) begin
            kind = int'($urandom_range(0, 7));
            imm = $urandom;
            if (kind == 4) begin
                case ($urandom_range(0, 2))
                    0: imm = imm & 32'h0000_FFFF;
                    1: imm = imm & 32'hFFFF_0000;
                    default: imm = imm;
                endcase
            end
            send(kind, int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
                 int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                 int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), imm);
        end
        drain();
        rnd_ready = 1'b0;

        // Asynchronous reset during OUT2 of a BLT.
        send(6, 0, 0, 4, 5, 0, 0, 32'h3);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("arst_valid", 32'(instr_valid), 32'd0);
        chk("arst_instr", instr, 32'd0);
        chk("arst_cnt", 32'(instr_cnt), 32'd0);
        #20 reset = 1'b1;
        send(3, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF);
        drain();
        chk("post_rst_cnt", 32'(instr_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Sequential instruction generator for the MIPS subset our CPU decodes. It turns a command stream (instruction class, register fields, immediate) into 32-bit machine words on a valid/ready output stream.
- Pseudo-ops (li, move, blt, bge) expand to one or two real instructions.
- Used as the program-image / self-test stimulus source that feeds the IM/fetch side of the pipeline, i.e. the producer end of the decode path.

Parameters:
AT_REG, 1, scratch register number used by blt/bge expansion ($at)
CNT_W, 16, width of the emitted-word counter

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
cmd_valid  input  1  command present
cmd_ready  output  1  encoder can accept a command
cmd_kind  input  3  0 R, 1 I, 2 J, 3 NOP, 4 LI, 5 MOVE, 6 BLT, 7 BGE
cmd_op  input  6  primary opcode for I/J kinds
cmd_func  input  6  funct for R kind
cmd_rs  input  5  rs field
cmd_rt  input  5  rt field
cmd_rd  input  5  rd field
cmd_shamt  input  5  shamt field for R kind
cmd_imm  input  32  immediate: [15:0] I/branch, [25:0] J, full 32 for LI
instr_valid  output  1  instr holds a valid word
instr_ready  input  1  consumer accepts word
instr  output  32  encoded instruction
instr_last  output  1  word is the final word of its command
instr_cnt  output  CNT_W  total words accepted by consumer, wraps

Behaviour:
- FSM states: IDLE, OUT1, OUT2. cmd_ready = (state == IDLE). One command per 2+ cycles is the accepted throughput.
- Accept: cmd_valid & cmd_ready captures all cmd fields into registers. Next cycle: state OUT1, instr_valid = 1, instr = word1.
- Output hold: instr, instr_valid and instr_last stay stable until instr_ready = 1.
- Transfer (instr_valid & instr_ready):
  - instr_cnt increments; wraps from all-ones to 0.
  - If the command has a second word: OUT1 -> OUT2 with instr = word2 in the next cycle.
  - Otherwise: -> IDLE, instr_valid = 0.
  - OUT2 transfer -> IDLE.
- instr_last = 1 on a single-word command's only word and on OUT2's word.
- Encoding per kind:
  - R: {6'b0, rs, rt, rd, shamt, func}
  - I: {op, rs, rt, imm[15:0]}
  - J: {op, imm[25:0]}
  - NOP: 32'h0
  - MOVE: addu rd, rs, $0
  - LI (target rt), 1 word when possible:
    - imm[31:16] == 0 -> ori rt, $0, imm[15:0]
    - else imm[15:0] == 0 -> lui rt, imm[31:16]
    - else two words: lui rt, imm[31:16]; ori rt, rt, imm[15:0]
  - BLT: slt AT_REG, rs, rt; bne AT_REG, $0, imm[15:0]
  - BGE: slt AT_REG, rs, rt; beq AT_REG, $0, imm[15:0]
- Branch offsets are passed through unchanged. The offset applies to the second word; the caller accounts for the extra slt.
- No decode validation: cmd_op/cmd_func are emitted verbatim.
- Reset (reset = 0), asynchronous:
  - state IDLE, instr_valid 0, instr 0, instr_last 0, instr_cnt 0.
  - A pending word or second word is discarded.
  - cmd_ready = 1 from the first edge after reset deasserts.
- Input handshake: cmd_valid asserted while cmd_ready = 0 is ignored. The producer holds the command until it is accepted.
- Simultaneous events: instr_ready may be high before instr_valid; no transfer occurs without instr_valid.

Test Plan:
- LI rt=8, imm=0x12345678, instr_ready=1 -> 0x3C081234 (last=0) then 0x35085678 (last=1); instr_cnt=2; cmd_ready back to 1 next cycle.
- LI rt=9, imm=0x0000ABCD -> single 0x3409ABCD, last=1. LI rt=9, imm=0x00010000 -> single 0x3C090001.
- R kind rs=1, rt=2, rd=3, shamt=0, func=0x21 -> 0x00221821. MOVE rd=2, rs=7 -> 0x00E01021.
- BLT rs=4, rt=5, imm=3, AT_REG=1 -> 0x0085082A then 0x14200003. BGE same fields -> second word 0x10200003.
- Backpressure: instr_ready low 3 cycles during OUT1 of an LI -> instr/instr_last unchanged, cmd_ready=0, instr_cnt unchanged; then transfers proceed in order.
- Reset asserted during OUT2 of a BLT -> instr_valid=0, instr=0, instr_cnt=0 immediately (asynchronous); after release, a NOP command yields 0x00000000 with last=1 and instr_cnt=1.
